// File: rtl/alu_mem_skid_stage_pkg.sv
// Shared widths, reset constants and helpers for the ALU->MEM skid stage.
// Define ALU_MEM_STALL_CNT_EN to add the stallCount output on the top.
package alu_mem_skid_stage_pkg;

  localparam int DATA_SIZE     = 32;
  localparam int REG_ADDR_SIZE = 5;

  localparam logic [DATA_SIZE-1:0]     DATA_BUS_RESET = '0;
  localparam logic [REG_ADDR_SIZE-1:0] REG_ADDR_RESET = '0;

  // Writes to x0 are architecturally dead, so the enable is dropped at capture.
  function automatic logic store_we(input logic we, input logic addr_zero, input logic suppress);
    return we & ~(suppress & addr_zero);
  endfunction

endpackage

// File: rtl/alu_mem_skid_stage_pipe_slot.sv
// One valid+payload register of the skid stage: load, drop, synchronous clear.
// Payload only changes on a real load so idle outputs hold their last value.
module alu_mem_skid_stage_pipe_slot
  import alu_mem_skid_stage_pkg::*;
#(
  parameter int DW = DATA_SIZE,
  parameter int AW = REG_ADDR_SIZE
) (
  input  logic          clk,
  input  logic          resetIn,
  input  logic          clear,
  input  logic          load,
  input  logic          drop,
  input  logic [DW-1:0] data_d,
  input  logic          we_d,
  input  logic [AW-1:0] addr_d,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic          we,
  output logic [AW-1:0] addr
);

  always_ff @(posedge clk or negedge resetIn) begin
    if (!resetIn) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetIn) begin
    if (!resetIn) begin
      data <= DW'(DATA_BUS_RESET);
      we   <= 1'b0;
      addr <= AW'(REG_ADDR_RESET);
    end else if (load && !clear) begin
      data <= data_d;
      we   <= we_d;
      addr <= addr_d;
    end
  end

endmodule

// File: rtl/alu_mem_skid_stage.sv
// ALU->MEM pipeline register with valid/ready handshake and 2-entry skid buffer.
// Optional ALU_MEM_STALL_CNT_EN adds a free-running stallCount output.
module alu_mem_skid_stage
  import alu_mem_skid_stage_pkg::*;
#(
  parameter int DATA_WIDTH        = DATA_SIZE,
  parameter int ADDR_WIDTH        = REG_ADDR_SIZE,
  parameter bit ZERO_REG_SUPPRESS = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetIn,
  input  logic                  flushIn,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  writeEnableIn,
  input  logic [ADDR_WIDTH-1:0] writeBackAddrIn,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  writeEnableOut,
  output logic [ADDR_WIDTH-1:0] writeBackAddrOut,
  output logic [1:0]            occupancy
`ifdef ALU_MEM_STALL_CNT_EN
  ,
  output logic [31:0]           stallCount
`endif
);

  logic                  main_valid, skid_valid;
  logic [DATA_WIDTH-1:0] main_data, skid_data, main_data_d;
  logic                  main_we, skid_we, main_we_d, in_we;
  logic [ADDR_WIDTH-1:0] main_addr, skid_addr, main_addr_d;
  logic                  accept, fire;
  logic                  main_load, main_drop, skid_load, skid_drop;

  assign inReady = ~skid_valid;
  assign accept  = inValid & inReady;
  assign fire    = main_valid & outReady;
  assign in_we   = store_we(writeEnableIn, writeBackAddrIn == '0, ZERO_REG_SUPPRESS);

  // Main refills from skid when it holds an entry, otherwise straight from input.
  assign main_load   = (fire & skid_valid) | (fire & accept) | (~main_valid & accept);
  assign main_drop   = fire & ~skid_valid & ~accept;
  assign main_data_d = skid_valid ? skid_data : dataIn;
  assign main_we_d   = skid_valid ? skid_we   : in_we;
  assign main_addr_d = skid_valid ? skid_addr : writeBackAddrIn;

  // Accept is impossible while skid is full, so skid only ever loads when main stalls.
  assign skid_load = accept & main_valid & ~fire;
  assign skid_drop = fire;

  alu_mem_skid_stage_pipe_slot #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_main (
    .clk    (clk),
    .resetIn(resetIn),
    .clear  (flushIn),
    .load   (main_load),
    .drop   (main_drop),
    .data_d (main_data_d),
    .we_d   (main_we_d),
    .addr_d (main_addr_d),
    .valid  (main_valid),
    .data   (main_data),
    .we     (main_we),
    .addr   (main_addr)
  );

  alu_mem_skid_stage_pipe_slot #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_skid (
    .clk    (clk),
    .resetIn(resetIn),
    .clear  (flushIn),
    .load   (skid_load),
    .drop   (skid_drop),
    .data_d (dataIn),
    .we_d   (in_we),
    .addr_d (writeBackAddrIn),
    .valid  (skid_valid),
    .data   (skid_data),
    .we     (skid_we),
    .addr   (skid_addr)
  );

  assign outValid         = main_valid;
  assign dataOut          = main_data;
  assign writeBackAddrOut = main_addr;
  assign writeEnableOut   = main_we & main_valid;
  assign occupancy        = {1'b0, main_valid} + {1'b0, skid_valid};

`ifdef ALU_MEM_STALL_CNT_EN
  // Wraps naturally; flush deliberately leaves it alone.
  always_ff @(posedge clk or negedge resetIn) begin
    if (!resetIn) begin
      stallCount <= '0;
    end else if (main_valid && !outReady) begin
      stallCount <= stallCount + 32'd1;
    end
  end
`endif

  skid_implies_main : assert property (@(posedge clk) disable iff (!resetIn) skid_valid |-> main_valid);

endmodule

// File: tb/tb_alu_mem_skid_stage.sv
// Randomized and directed bench for alu_mem_skid_stage against a queue model.
// Runs a second instance with ZERO_REG_SUPPRESS=0 on the same inputs.
module tb_alu_mem_skid_stage;

  logic        clk = 1'b0;
  logic        resetIn = 1'b0;
  logic        flushIn = 1'b0;
  logic        inValid = 1'b0;
  logic [31:0] dataIn = '0;
  logic        writeEnableIn = 1'b0;
  logic [4:0]  writeBackAddrIn = '0;
  logic        outReady = 1'b0;

  logic        inReady, outValid, writeEnableOut;
  logic [31:0] dataOut;
  logic [4:0]  writeBackAddrOut;
  logic [1:0]  occupancy;
  logic        inReady2, outValid2, writeEnableOut2;
  logic [31:0] dataOut2;
  logic [4:0]  writeBackAddrOut2;
  logic [1:0]  occupancy2;
`ifdef ALU_MEM_STALL_CNT_EN
  logic [31:0] stallCount, stallCount2;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] d;
    logic        we;
    logic [4:0]  a;
  } ent_t;

  ent_t        q[$];
  int unsigned stall_m = 0;

  always #5 clk = ~clk;

  alu_mem_skid_stage dut (
    .clk(clk), .resetIn(resetIn), .flushIn(flushIn), .inValid(inValid), .inReady(inReady),
    .dataIn(dataIn), .writeEnableIn(writeEnableIn), .writeBackAddrIn(writeBackAddrIn),
    .outValid(outValid), .outReady(outReady), .dataOut(dataOut), .writeEnableOut(writeEnableOut),
    .writeBackAddrOut(writeBackAddrOut), .occupancy(occupancy)
`ifdef ALU_MEM_STALL_CNT_EN
    , .stallCount(stallCount)
`endif
  );

  alu_mem_skid_stage #(.ZERO_REG_SUPPRESS(1'b0)) dut_nosup (
    .clk(clk), .resetIn(resetIn), .flushIn(flushIn), .inValid(inValid), .inReady(inReady2),
    .dataIn(dataIn), .writeEnableIn(writeEnableIn), .writeBackAddrIn(writeBackAddrIn),
    .outValid(outValid2), .outReady(outReady), .dataOut(dataOut2), .writeEnableOut(writeEnableOut2),
    .writeBackAddrOut(writeBackAddrOut2), .occupancy(occupancy2)
`ifdef ALU_MEM_STALL_CNT_EN
    , .stallCount(stallCount2)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a 2-deep FIFO; pop on consume, push on accept, flush empties it.
  task automatic model_step();
    bit acc, fire;
    acc  = inValid && (q.size() < 2);
    fire = (q.size() > 0) && outReady;
    if (q.size() > 0 && !outReady) stall_m++;
    if (flushIn) begin
      q.delete();
    end else begin
      if (fire) void'(q.pop_front());
      if (acc) q.push_back('{d: dataIn, we: writeEnableIn, a: writeBackAddrIn});
    end
  endtask

  task automatic compare();
    chk("out_valid", outValid, q.size() > 0);
    chk("occupancy", occupancy, q.size());
    chk("in_ready", inReady, q.size() < 2);
    chk("out_valid_nosup", outValid2, q.size() > 0);
    chk("occupancy_nosup", occupancy2, q.size());
    if (q.size() > 0) begin
      chk("data_out", dataOut, q[0].d);
      chk("addr_out", writeBackAddrOut, q[0].a);
      chk("we_out", writeEnableOut, q[0].we && (q[0].a != 0));
      chk("data_out_nosup", dataOut2, q[0].d);
      chk("we_out_nosup", writeEnableOut2, q[0].we);
    end else begin
      chk("we_out_idle", writeEnableOut, 1'b0);
      chk("we_out_idle_nosup", writeEnableOut2, 1'b0);
    end
`ifdef ALU_MEM_STALL_CNT_EN
    chk("stall_count", stallCount, stall_m);
`endif
  endtask

  // Inputs are changed only at the falling edge; the model sees the values the DUT samples.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic we, input logic [4:0] a);
    inValid = v;
    dataIn = d;
    writeEnableIn = we;
    writeBackAddrIn = a;
  endtask

  task automatic do_reset(input int cycles);
    resetIn = 1'b0;
    drive(1'b0, '0, 1'b0, '0);
    flushIn = 1'b0;
    repeat (cycles) @(negedge clk);
    q.delete();
    stall_m = 0;
    resetIn = 1'b1;
  endtask

  initial begin
    logic [31:0] stream_d [3];
    stream_d[0] = 32'h11;
    stream_d[1] = 32'h22;
    stream_d[2] = 32'h33;

    do_reset(3);
    chk("rst_data", dataOut, 32'h0);
    chk("rst_addr", writeBackAddrOut, 5'h0);
    compare();
    tick();

    outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, stream_d[i], 1'b1, 5'd5);
      tick();
      chk("stream_data", dataOut, stream_d[i]);
      chk("stream_we", writeEnableOut, 1'b1);
    end
    drive(1'b0, '0, 1'b0, '0);
    tick();

    outReady = 1'b0;
    drive(1'b1, 32'hA0, 1'b1, 5'd7);
    tick();
    drive(1'b1, 32'hA1, 1'b1, 5'd8);
    tick();
    chk("bp_occ_full", occupancy, 2'd2);
    chk("bp_not_ready", inReady, 1'b0);
    drive(1'b1, 32'hA2, 1'b1, 5'd9);
    tick();
    chk("bp_still_held", dataOut, 32'hA0);
    outReady = 1'b1;
    tick();
    chk("bp_second", dataOut, 32'hA1);
    tick();
    chk("bp_third", dataOut, 32'hA2);
    drive(1'b0, '0, 1'b0, '0);
    tick();
    chk("bp_drained", outValid, 1'b0);

    outReady = 1'b0;
    drive(1'b1, 32'hDEAD, 1'b1, 5'd0);
    tick();
    chk("x0_data", dataOut, 32'hDEAD);
    chk("x0_we_sup", writeEnableOut, 1'b0);
    chk("x0_we_nosup", writeEnableOut2, 1'b1);

    drive(1'b1, 32'h55, 1'b1, 5'd3);
    tick();
    chk("fl_full", occupancy, 2'd2);
    flushIn = 1'b1;
    drive(1'b1, 32'h77, 1'b1, 5'd4);
    tick();
    chk("fl_valid", outValid, 1'b0);
    chk("fl_occ", occupancy, 2'd0);
    chk("fl_ready", inReady, 1'b1);
    flushIn = 1'b0;
    drive(1'b0, '0, 1'b0, '0);
    outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_no_77", (outValid && dataOut == 32'h77), 1'b0);
    end

    do_reset(2);
    outReady = 1'b0;
    drive(1'b1, 32'hBEEF, 1'b1, 5'd12);
    tick();
    drive(1'b0, '0, 1'b0, '0);
    repeat (10) tick();
`ifdef ALU_MEM_STALL_CNT_EN
    chk("stall_ten", stallCount, 32'd10);
`endif
    #2;
    resetIn = 1'b0;
    #1;
    chk("async_valid", outValid, 1'b0);
    chk("async_occ", occupancy, 2'd0);
    chk("async_data", dataOut, 32'h0);
    chk("async_we", writeEnableOut, 1'b0);
    chk("async_ready", inReady, 1'b1);
`ifdef ALU_MEM_STALL_CNT_EN
    chk("async_stall", stallCount, 32'd0);
`endif
    do_reset(2);
    compare();

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom,
            $urandom_range(0, 1) == 1,
            ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
      outReady = $urandom_range(0, 2) != 0;
      flushIn = $urandom_range(0, 24) == 0;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_mem_skid_stage.md
Name: alu_mem_skid_stage

Overview:
- Parametrised successor to the ALU->MEM pipeline register in the RISC-V core.
- Carries ALU result, write-back enable and write-back address from execute to memory stage.
- Adds a valid/ready handshake with a 2-entry skid buffer, so the memory stage can stall without a combinational ready path back to decode.
- Adds a synchronous flush for branch/trap squash, and suppresses write-back to x0.

Parameters:
- DATA_WIDTH, 32, width of ALU result / memory data path.
- ADDR_WIDTH, 5, width of register-file write-back address.
- ZERO_REG_SUPPRESS, 1, when 1 writeEnableOut is forced 0 for address 0.

Ports:
- clk  input  1  core clock, rising edge.
- resetIn  input  1  asynchronous, active-low reset.
- flushIn  input  1  synchronous squash of all held entries.
- inValid  input  1  upstream has a valid ALU result.
- inReady  output  1  stage can accept this cycle.
- dataIn  input  DATA_WIDTH  ALU result.
- writeEnableIn  input  1  register write-back request.
- writeBackAddrIn  input  ADDR_WIDTH  destination register.
- outValid  output  1  head entry valid toward memory stage.
- outReady  input  1  memory stage consumes head this cycle.
- dataOut  output  DATA_WIDTH  head entry data.
- writeEnableOut  output  1  head write enable, gated by outValid.
- writeBackAddrOut  output  ADDR_WIDTH  head destination register.
- occupancy  output  2  entries held, 0..2.

Behaviour:
- Storage: main slot (drives outputs) plus skid slot. Each slot holds a valid bit, data, we and addr.
- inReady = !skidValid. It is purely a register output, with no combinational path from outReady.
- Accept = inValid & inReady. Fire = outValid & outReady.
- Per clock edge, absent flush:
  - Fire & skidValid: main <= skid; skid <= accepted entry if Accept, else skid invalid.
  - Fire & !skidValid: main <= accepted entry if Accept, else main invalid.
  - !Fire & mainValid & Accept: skid <= accepted entry.
  - !mainValid & Accept: main <= accepted entry.
- Latency is 1 cycle from Accept to outValid when empty. Sustained throughput is 1 entry/cycle with outReady held high.
- Ordering is strictly FIFO.
- Payload registers load only on write. When outValid=0, dataOut and writeBackAddrOut hold stale values and writeEnableOut=0.
- Write enable: stored we = writeEnableIn & !(ZERO_REG_SUPPRESS && writeBackAddrIn==0). writeEnableOut = mainWe & mainValid.
- Flush:
  - Both valid bits are cleared on the next edge.
  - An input accepted in the flush cycle is dropped.
  - An entry firing in the flush cycle is still consumed downstream (it is already visible).
  - Flush has priority over all other updates.
- Reset (resetIn=0, asynchronous): all valids 0; dataOut 0; writeBackAddrOut 0; writeEnableOut 0; occupancy 0; inReady 1. Reset mid-transfer discards all held entries.
- occupancy = mainValid + skidValid. skidValid implies mainValid; a violation is a design error and is asserted in simulation.
- Full: occupancy=2, so inReady=0 and inValid is ignored.
- Empty: outValid=0, so outReady is ignored.

Optional Feature:
- Macro ALU_MEM_STALL_CNT_EN.
- When defined, adds output stallCount [31:0]. It counts cycles with outValid & !outReady, wraps at 2^32-1 to 0, resets to 0 on resetIn, and is not cleared by flush.
- When undefined, the port and counter are absent and all other behaviour is identical.

Decomposition:
- Shared header define.v carries:
  - DataSize/RegAddrSize-style width macros matching DATA_WIDTH/ADDR_WIDTH defaults.
  - DataBusReset and RegAddrReset reset constants.
  - The ALU_MEM_STALL_CNT_EN switch comment.
- One sub-module is natural: pipe_slot. It is a single valid+payload register with load enable, clear (flush) and asynchronous active-low reset, instantiated twice (main, skid).

Test Plan:
- Reset then idle: resetIn low for 3 cycles, release, inValid=0 → outValid=0, writeEnableOut=0, dataOut=0, inReady=1, occupancy=0.
- Streaming: outReady=1, push data 0x11,0x22,0x33 on consecutive cycles with addr 5, we 1 → same sequence on dataOut one cycle later, occupancy never exceeds 1, writeEnableOut=1.
- Backpressure: outReady=0, push 0xA0, 0xA1, 0xA2 → occupancy 2 after two accepts, inReady=0, 0xA2 held upstream. Raise outReady → outputs 0xA0, 0xA1, 0xA2 in order with no loss or duplication.
- x0 suppression: push we=1 addr=0 data=0xDEAD → outValid=1, dataOut=0xDEAD, writeEnableOut=0. With ZERO_REG_SUPPRESS=0 → writeEnableOut=1.
- Flush: fill to occupancy 2, assert flushIn together with inValid (data 0x77) → next cycle outValid=0, occupancy=0, inReady=1, 0x77 never appears.
- Async reset mid-stall (ALU_MEM_STALL_CNT_EN defined): stall 10 cycles with outValid=1 → stallCount=10. Drop resetIn between edges → outputs clear immediately, stallCount=0.
